// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface pc_fetch_unit_if;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;

  modport master (output imemReq, output imemAddr, input imemAck, input imemData);
  modport slave  (input imemReq, input imemAddr, output imemAck, output imemData);
endinterface

// File: rtl/pc_fetch_unit.sv
// Fetch/PC stage: walks the PC, fetches over imem req/ack, hands one instruction
// at a time to decode and applies branch and exception redirects.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    shouldUseNewPC,
  input  logic [31:0]             branchTo,
  input  logic                    exceptionRedirect,
  input  logic                    stall,
  pc_fetch_unit_if.master         imem,
  output logic                    instrValid,
  output logic [31:0]             instruction,
  output logic [31:0]             pcAddress,
  output logic                    misaligned
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

  state_t      state_q;
  logic [31:0] fetch_pc_q;
  logic        drop_q;
  logic        req_q;
  logic [31:0] addr_q;
  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pcaddr_q;
  logic        mis_q;

  logic [31:0] pc_plus4_d;
  logic [31:0] next_pc_d;

  assign pc_plus4_d = fetch_pc_q + 32'd4;
  // fetch_pc already points past the held instruction; only a taken branch moves it
  assign next_pc_d  = shouldUseNewPC ? {branchTo[31:2], 2'b00} : fetch_pc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_VECTOR;
      drop_q     <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= 32'h0;
      valid_q    <= 1'b0;
      instr_q    <= 32'h0;
      pcaddr_q   <= 32'h0;
      mis_q      <= 1'b0;
    end else begin
      mis_q <= 1'b0;
      case (state_q)
        BOOT: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
          addr_q  <= fetch_pc_q;
        end
        FETCH: begin
          if (imem.imemAck) begin
            if (drop_q || exceptionRedirect) begin
              // squashed response: re-issue immediately at the exception vector
              drop_q     <= 1'b0;
              fetch_pc_q <= EXC_VECTOR;
              addr_q     <= EXC_VECTOR;
            end else begin
              instr_q    <= imem.imemData;
              pcaddr_q   <= pc_plus4_d;
              fetch_pc_q <= pc_plus4_d;
              valid_q    <= 1'b1;
              req_q      <= 1'b0;
              state_q    <= HOLD;
            end
          end else if (exceptionRedirect) begin
            drop_q <= 1'b1;
          end
        end
        HOLD: begin
          if (exceptionRedirect) begin
            valid_q    <= 1'b0;
            fetch_pc_q <= EXC_VECTOR;
            addr_q     <= EXC_VECTOR;
            req_q      <= 1'b1;
            state_q    <= FETCH;
          end else if (!stall) begin
            valid_q    <= 1'b0;
            fetch_pc_q <= next_pc_d;
            addr_q     <= next_pc_d;
            req_q      <= 1'b1;
            mis_q      <= shouldUseNewPC && (branchTo[1:0] != 2'b00);
            state_q    <= FETCH;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

  assign imem.imemReq  = req_q;
  assign imem.imemAddr = addr_q;
  assign instrValid    = valid_q;
  assign instruction   = instr_q;
  assign pcAddress     = pcaddr_q;
  assign misaligned    = mis_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed walk through the fetch scenarios, then
// randomized traffic against a transaction-level fetch model.
module tb_pc_fetch_unit;
  localparam logic [31:0] EXC = 32'h0000_0180;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        shouldUseNewPC = 1'b0;
  logic [31:0] branchTo = 32'h0;
  logic        exceptionRedirect = 1'b0;
  logic        stall = 1'b0;
  logic        instrValid;
  logic [31:0] instruction;
  logic [31:0] pcAddress;
  logic        misaligned;

  pc_fetch_unit_if imem_if ();

  pc_fetch_unit #(.RESET_VECTOR(32'h0), .EXC_VECTOR(EXC)) dut (
    .clk(clk), .rst(rst),
    .shouldUseNewPC(shouldUseNewPC), .branchTo(branchTo),
    .exceptionRedirect(exceptionRedirect), .stall(stall),
    .imem(imem_if),
    .instrValid(instrValid), .instruction(instruction),
    .pcAddress(pcAddress), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: what the fetch stage should be showing the outside world.
  bit          m_req, m_valid, m_mis, m_drop;
  logic [31:0] m_pc, m_addr, m_instr, m_pcaddr;

  task automatic model_reset();
    m_req = 0; m_valid = 0; m_mis = 0; m_drop = 0;
    m_pc = 32'h0; m_addr = 32'h0; m_instr = 32'h0; m_pcaddr = 32'h0;
  endtask

  task automatic model_step(input bit st, input bit su, input logic [31:0] bt,
                            input bit ex, input bit ak, input logic [31:0] dt);
    m_mis = 0;
    if (!m_req && !m_valid) begin           // just out of reset: start fetching
      m_req = 1; m_addr = m_pc;
    end else if (m_req) begin               // request outstanding
      if (ak) begin
        if (m_drop || ex) begin
          m_drop = 0; m_pc = EXC; m_addr = EXC;
        end else begin
          m_instr = dt; m_pcaddr = m_pc + 32'd4; m_pc = m_pc + 32'd4;
          m_valid = 1; m_req = 0;
        end
      end else if (ex) m_drop = 1;
    end else begin                          // instruction presented to decode
      if (ex) begin
        m_valid = 0; m_pc = EXC; m_req = 1; m_addr = EXC;
      end else if (!st) begin
        if (su) begin
          m_pc = {bt[31:2], 2'b00};
          m_mis = (bt[1:0] != 2'b00);
        end
        m_valid = 0; m_req = 1; m_addr = m_pc;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".req"}, {31'h0, imem_if.imemReq}, {31'h0, m_req});
    if (m_req) chk({tag, ".addr"}, imem_if.imemAddr, m_addr);
    chk({tag, ".valid"}, {31'h0, instrValid}, {31'h0, m_valid});
    if (m_valid) begin
      chk({tag, ".instr"}, instruction, m_instr);
      chk({tag, ".pcaddr"}, pcAddress, m_pcaddr);
    end
    chk({tag, ".mis"}, {31'h0, misaligned}, {31'h0, m_mis});
  endtask

  task automatic cycle(input string tag, input bit st, input bit su, input logic [31:0] bt,
                       input bit ex, input bit ak, input logic [31:0] dt);
    stall = st; shouldUseNewPC = su; branchTo = bt; exceptionRedirect = ex;
    imem_if.imemAck = ak; imem_if.imemData = dt;
    model_step(st, su, bt, ex, ak, dt);
    @(posedge clk); #1;
    check_all(tag);
  endtask

  initial begin
    int lat;
    bit st, su, ex, ak;
    logic [31:0] bt, dt;
    imem_if.imemAck = 1'b0;
    imem_if.imemData = 32'h0;
    model_reset();

    // reset state
    #2;
    chk("rst.req", {31'h0, imem_if.imemReq}, 32'h0);
    chk("rst.addr", imem_if.imemAddr, 32'h0);
    chk("rst.valid", {31'h0, instrValid}, 32'h0);
    chk("rst.instr", instruction, 32'h0);
    chk("rst.pcaddr", pcAddress, 32'h0);
    chk("rst.mis", {31'h0, misaligned}, 32'h0);
    @(posedge clk); #1 rst = 1'b1;

    // boot, zero-wait ack
    cycle("boot", 0, 0, 0, 0, 0, 0);
    chk("t1.addr", imem_if.imemAddr, 32'h0);
    cycle("t1", 0, 0, 0, 0, 1, 32'h2008_0005);
    chk("t1.instr", instruction, 32'h2008_0005);
    chk("t1.pcaddr", pcAddress, 32'h4);
    cycle("t1c", 0, 0, 0, 0, 0, 0);
    chk("t1.next", imem_if.imemAddr, 32'h4);

    // 3-cycle latency, then 2 stall cycles
    cycle("t2w", 0, 0, 0, 0, 0, 0);
    chk("t2.stable", imem_if.imemAddr, 32'h4);
    cycle("t2w", 0, 0, 0, 0, 0, 0);
    cycle("t2a", 0, 0, 0, 0, 1, 32'h1234_5678);
    cycle("t2s", 1, 0, 0, 0, 0, 0);
    cycle("t2s", 1, 0, 0, 0, 0, 0);
    chk("t2.held", instruction, 32'h1234_5678);
    cycle("t2c", 0, 0, 0, 0, 0, 0);
    chk("t2.next", imem_if.imemAddr, 32'h8);

    // taken branches, misaligned then aligned target
    cycle("t3a", 0, 0, 0, 0, 1, 32'h0000_0013);
    cycle("t3b", 0, 1, 32'hAABB_CCD9, 0, 0, 0);
    chk("t3.addr", imem_if.imemAddr, 32'hAABB_CCD8);
    chk("t3.mis", {31'h0, misaligned}, 32'h1);
    cycle("t3a", 0, 0, 0, 0, 1, 32'h0000_0033);
    chk("t3.mis_off", {31'h0, misaligned}, 32'h0);
    cycle("t3b", 0, 1, 32'hA2AA_EF30, 0, 0, 0);
    chk("t3.addr2", imem_if.imemAddr, 32'hA2AA_EF30);

    // redirect while stalled is ignored
    cycle("t4a", 0, 0, 0, 0, 1, 32'h0000_0044);
    cycle("t4s", 1, 1, 32'h0000_1000, 0, 0, 0);
    cycle("t4c", 0, 0, 0, 0, 0, 0);
    chk("t4.addr", imem_if.imemAddr, 32'hA2AA_EF34);

    // exception two cycles before ack at 0x10
    cycle("t5a", 0, 0, 0, 0, 1, 32'h0000_0055);
    cycle("t5b", 0, 1, 32'h0000_0010, 0, 0, 0);
    cycle("t5e", 0, 0, 0, 1, 0, 0);
    cycle("t5w", 0, 0, 0, 0, 0, 0);
    cycle("t5k", 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    chk("t5.valid", {31'h0, instrValid}, 32'h0);
    chk("t5.addr", imem_if.imemAddr, EXC);
    cycle("t5a", 0, 0, 0, 0, 1, 32'h0000_0066);
    cycle("t5x", 0, 1, 32'h0000_2000, 1, 0, 0);
    chk("t5.excwins", imem_if.imemAddr, EXC);

    // wrap at the top of the address space
    cycle("t6a", 0, 0, 0, 0, 1, 32'h0000_0077);
    cycle("t6b", 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    cycle("t6k", 0, 0, 0, 0, 1, 32'h0000_0088);
    chk("t6.pcaddr", pcAddress, 32'h0);
    cycle("t6c", 0, 0, 0, 0, 0, 0);
    chk("t6.next", imem_if.imemAddr, 32'h0);

    // reset mid-request; ack during reset ignored
    #3 rst = 1'b0;
    #1 chk("t7.req_async", {31'h0, imem_if.imemReq}, 32'h0);
    imem_if.imemAck = 1'b1;
    @(posedge clk); #1;
    chk("t7.req_rst", {31'h0, imem_if.imemReq}, 32'h0);
    chk("t7.valid_rst", {31'h0, instrValid}, 32'h0);
    imem_if.imemAck = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    cycle("t7b", 0, 0, 0, 0, 0, 0);
    chk("t7.restart", imem_if.imemAddr, 32'h0);

    // randomized traffic with variable memory latency
    lat = -1;
    for (int i = 0; i < 2500; i++) begin
      if (m_req && lat < 0) lat = int'($urandom_range(0, 3));
      ak = m_req && (lat == 0);
      dt = $urandom;
      st = ($urandom_range(0, 2) == 0);
      su = ($urandom_range(0, 2) == 0);
      ex = ($urandom_range(0, 19) == 0);
      bt = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
      if (!su || ex || $urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
      cycle("rnd", st, su, bt, ex, ak, dt);
      if (ak) lat = -1;
      else if (lat > 0) lat--;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch / program-counter stage directly downstream of the Branch unit.
- Consumes shouldUseNewPC/branchTo, maintains the fetch PC and fetches instructions over a req/ack instruction-memory handshake.
- Presents one instruction at a time to decode, together with its PC+4, which feeds Branch pcAddress.
- Also accepts an asynchronous-to-pipeline exception redirect that may arrive mid-fetch.

Parameters:
RESET_VECTOR, 32'h0000_0000, first fetch address after reset
EXC_VECTOR, 32'h0000_0180, fetch address taken on exceptionRedirect

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
shouldUseNewPC  in  1  from Branch: take branchTo when current instruction retires
branchTo  in  32  from Branch: redirect target
exceptionRedirect  in  1  one-cycle request to refetch from EXC_VECTOR
stall  in  1  decode cannot accept the presented instruction
imemReq  out  1  fetch request; held with stable imemAddr until imemAck
imemAddr  out  32  word address being fetched
imemAck  in  1  imemData valid this cycle; completes request
imemData  in  32  fetched instruction word
instrValid  out  1  instruction/pcAddress valid for decode
instruction  out  32  presented instruction
pcAddress  out  32  address of presented instruction + 4
misaligned  out  1  one-cycle pulse: branchTo[1:0] was nonzero

Behaviour:
- Reset (rst=0, async):
  - state=BOOT, fetchPc=RESET_VECTOR, dropPending=0.
  - All outputs 0: imemReq, imemAddr, instrValid, instruction, pcAddress, misaligned.
- States BOOT, FETCH, HOLD. All outputs are registered.
- BOOT: next edge -> FETCH. imemReq=1 and imemAddr=fetchPc from that edge.
- FETCH:
  - imemReq=1; imemAddr=fetchPc, constant until ack.
  - On ack with dropPending=0: instruction<=imemData, pcAddress<=fetchPc+4 (mod 2^32), instrValid<=1, imemReq<=0, fetchPc<=fetchPc+4, -> HOLD.
  - On ack with dropPending=1: discard data, dropPending<=0, fetchPc<=EXC_VECTOR, stay FETCH. imemAddr becomes EXC_VECTOR next cycle; req stays high.
  - Memory latency: ack may be the first request cycle or any later cycle.
- HOLD:
  - instrValid=1; outputs frozen while stall=1.
  - On edge with stall=0 (instruction consumed): instrValid<=0, -> FETCH.
  - If shouldUseNewPC=1 on that edge: fetchPc<={branchTo[31:2],2'b00}; otherwise fetchPc is unchanged (already PC+4).
  - If branchTo[1:0]!=0 on that edge: misaligned<=1 for exactly one cycle.
  - shouldUseNewPC is ignored when instrValid=0 or stall=1. No branch delay slot.
- exceptionRedirect (sampled every edge, any state except BOOT):
  - In HOLD: drop the presented instruction (instrValid<=0), fetchPc<=EXC_VECTOR, -> FETCH. Overrides stall and shouldUseNewPC.
  - In FETCH with imemAck the same cycle: discard data, fetchPc<=EXC_VECTOR, stay FETCH.
  - In FETCH without ack: dropPending<=1; the request completes unchanged, then its data is dropped as above.
  - A second exception while dropPending=1 has no additional effect.
- Throughput: zero-wait memory and stall=0 gives one instruction per 2 cycles (FETCH, HOLD).
- Wrap: fetchPc=32'hFFFF_FFFC increments to 32'h0000_0000; pcAddress wraps likewise.
- Reset asserted mid-request: imemReq drops immediately (async). An ack arriving during reset is ignored.

Test Plan:
- Reset release, RESET_VECTOR=0, ack on first request cycle with data 32'h2008_0005 -> imemAddr=0; next cycle instrValid=1, instruction=32'h2008_0005, pcAddress=32'h4; next fetch address 32'h4.
- Sequential fetch with 3-cycle ack latency and stall=1 for 2 cycles in HOLD -> imemAddr stable 0x4 while waiting; instruction held during stall; next imemAddr 0x8.
- HOLD with stall=0, shouldUseNewPC=1, branchTo=32'hAABBCCD9 -> next imemAddr=32'hAABBCCD8, misaligned pulses one cycle; repeat with branchTo=32'hA2AAEF30 -> imemAddr=32'hA2AAEF30, misaligned=0.
- Redirect ignored: shouldUseNewPC=1 while stall=1 -> no change; released with shouldUseNewPC=0 -> fetch continues at PC+4.
- exceptionRedirect in FETCH two cycles before ack at 0x10 -> data dropped, instrValid stays 0; next imemAddr=32'h0000_0180. Also exception together with shouldUseNewPC in HOLD -> EXC_VECTOR wins.
- fetchPc=32'hFFFF_FFFC ack -> pcAddress=0, next imemAddr=0. Then rst pulsed low mid-request -> imemReq=0 immediately, restart at RESET_VECTOR.
